// File: rtl/eth_axis_pkg.sv
// Shared defaults and lane mapping for the Ethernet AXI-Stream receive packer.
package eth_axis_pkg;

   localparam int unsigned DEF_S_DATA_WIDTH   = 8;
   localparam int unsigned DEF_RATIO          = 4;
   localparam int unsigned DEF_FIRST_LANE_MSB = 1;

   // Output lane that holds the k-th arriving beat of a word; the mapping is its own inverse.
   function automatic int unsigned lane_idx(input int unsigned k,
                                            input int unsigned ratio,
                                            input bit          first_msb);
      return first_msb ? (ratio - 1 - k) : k;
   endfunction

endpackage

// File: rtl/eth_axis_rx_packer.sv
// Packs narrow AXI-Stream beats into RATIO-lane words, one output register stage.
// A word closes on a full lane count or on tlast; unreceived lanes read as zero.
module eth_axis_rx_packer
   import eth_axis_pkg::*;
#(
   parameter int unsigned S_DATA_WIDTH   = DEF_S_DATA_WIDTH,
   parameter int unsigned RATIO          = DEF_RATIO,
   parameter int unsigned FIRST_LANE_MSB = DEF_FIRST_LANE_MSB
) (
   input  logic                                  clk_i,
   input  logic                                  rstn_i,
   input  logic [S_DATA_WIDTH-1:0]               s_axis_tdata,
   input  logic                                  s_axis_tvalid,
   input  logic                                  s_axis_tuser,
   input  logic                                  s_axis_tlast,
   output logic                                  s_axis_tready,
   output logic [S_DATA_WIDTH*RATIO-1:0]         m_axis_tdata,
   output logic [RATIO-1:0]                      m_axis_tkeep,
   output logic [$clog2(RATIO)-1:0]              m_axis_byte_count,
   output logic                                  m_axis_tvalid,
   output logic                                  m_axis_tlast,
   output logic                                  m_axis_tuser,
   input  logic                                  m_axis_tready
);

   localparam int unsigned M_DATA_WIDTH = S_DATA_WIDTH * RATIO;
   localparam int unsigned CNT_W        = $clog2(RATIO);
   localparam bit          MSB_FIRST    = (FIRST_LANE_MSB != 0);

   logic [CNT_W-1:0]        cnt,       cnt_d;
   logic [M_DATA_WIDTH-1:0] acc_data,  acc_data_d;
   logic                    tuser_acc, tuser_acc_d;

   logic [M_DATA_WIDTH-1:0] tdata_d;
   logic [RATIO-1:0]        tkeep_d;
   logic [CNT_W-1:0]        byte_count_d;
   logic                    tvalid_d, tlast_d, tuser_d;

   logic                    accept_c;
   logic                    complete_c;
   logic [CNT_W-1:0]        lane_c;
   logic [M_DATA_WIDTH-1:0] word_c;
   logic [RATIO-1:0]        keep_c;

   // Backpressure depends only on the output register, never on the incoming beat.
   assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
   assign accept_c      = s_axis_tvalid && s_axis_tready;
   assign complete_c    = accept_c && ((cnt == CNT_W'(RATIO - 1)) || s_axis_tlast);

   // Merge the current beat into the accumulator and derive the keep mask for cnt+1 lanes.
   always_comb begin
      lane_c = CNT_W'(lane_idx(32'(cnt), RATIO, MSB_FIRST));
      word_c = '0;
      keep_c = '0;
      for (int unsigned j = 0; j < RATIO; j++) begin
         if (CNT_W'(j) == lane_c) begin
            word_c[j*S_DATA_WIDTH +: S_DATA_WIDTH] = s_axis_tdata;
         end else begin
            word_c[j*S_DATA_WIDTH +: S_DATA_WIDTH] = acc_data[j*S_DATA_WIDTH +: S_DATA_WIDTH];
         end
         keep_c[j] = (CNT_W'(lane_idx(j, RATIO, MSB_FIRST)) <= cnt);
      end
   end

   // Next-state for the accumulator and the output register.
   always_comb begin
      cnt_d        = cnt;
      acc_data_d   = acc_data;
      tuser_acc_d  = tuser_acc;
      tdata_d      = m_axis_tdata;
      tkeep_d      = m_axis_tkeep;
      byte_count_d = m_axis_byte_count;
      tvalid_d     = m_axis_tvalid;
      tlast_d      = m_axis_tlast;
      tuser_d      = m_axis_tuser;

      if (m_axis_tready) begin
         tvalid_d = 1'b0;
      end

      if (complete_c) begin
         tdata_d      = word_c;
         tkeep_d      = keep_c;
         byte_count_d = cnt;
         tvalid_d     = 1'b1;
         tlast_d      = s_axis_tlast;
         tuser_d      = tuser_acc || s_axis_tuser;
         cnt_d        = '0;
         acc_data_d   = '0;
         tuser_acc_d  = 1'b0;
      end else if (accept_c) begin
         cnt_d        = cnt + CNT_W'(1);
         acc_data_d   = word_c;
         tuser_acc_d  = tuser_acc || s_axis_tuser;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt               <= '0;
         acc_data          <= '0;
         tuser_acc         <= 1'b0;
         m_axis_tdata      <= '0;
         m_axis_tkeep      <= '0;
         m_axis_byte_count <= '0;
         m_axis_tvalid     <= 1'b0;
         m_axis_tlast      <= 1'b0;
         m_axis_tuser      <= 1'b0;
      end else begin
         cnt               <= cnt_d;
         acc_data          <= acc_data_d;
         tuser_acc         <= tuser_acc_d;
         m_axis_tdata      <= tdata_d;
         m_axis_tkeep      <= tkeep_d;
         m_axis_byte_count <= byte_count_d;
         m_axis_tvalid     <= tvalid_d;
         m_axis_tlast      <= tlast_d;
         m_axis_tuser      <= tuser_d;
      end
   end

endmodule

// File: tb/tb_eth_axis_rx_packer.sv
// Bench for eth_axis_rx_packer: MSB-first and LSB-first instances share one input stream
// and are compared every cycle against a beat-queue reference model.
module tb_eth_axis_rx_packer;

   localparam int unsigned SW = 8;
   localparam int unsigned R  = 4;
   localparam int unsigned MW = SW * R;
   localparam int unsigned CW = 2;

   logic          clk = 1'b0;
   logic          rstn_i;
   logic [SW-1:0] s_tdata;
   logic          s_tvalid, s_tuser, s_tlast, m_tready;

   logic          s_tready_m, tvalid_m, tlast_m, tuser_m;
   logic [MW-1:0] tdata_m;
   logic [R-1:0]  tkeep_m;
   logic [CW-1:0] bc_m;
   logic          s_tready_l, tvalid_l, tlast_l, tuser_l;
   logic [MW-1:0] tdata_l;
   logic [R-1:0]  tkeep_l;
   logic [CW-1:0] bc_l;

   always #5 clk = ~clk;

   eth_axis_rx_packer #(.S_DATA_WIDTH(SW), .RATIO(R), .FIRST_LANE_MSB(1)) u_dut_msb (
      .clk_i(clk), .rstn_i(rstn_i),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tuser(s_tuser),
      .s_axis_tlast(s_tlast), .s_axis_tready(s_tready_m),
      .m_axis_tdata(tdata_m), .m_axis_tkeep(tkeep_m), .m_axis_byte_count(bc_m),
      .m_axis_tvalid(tvalid_m), .m_axis_tlast(tlast_m), .m_axis_tuser(tuser_m),
      .m_axis_tready(m_tready)
   );

   eth_axis_rx_packer #(.S_DATA_WIDTH(SW), .RATIO(R), .FIRST_LANE_MSB(0)) u_dut_lsb (
      .clk_i(clk), .rstn_i(rstn_i),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tuser(s_tuser),
      .s_axis_tlast(s_tlast), .s_axis_tready(s_tready_l),
      .m_axis_tdata(tdata_l), .m_axis_tkeep(tkeep_l), .m_axis_byte_count(bc_l),
      .m_axis_tvalid(tvalid_l), .m_axis_tlast(tlast_l), .m_axis_tuser(tuser_l),
      .m_axis_tready(m_tready)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: beats of the open word, plus the expected output register.
   logic [SW-1:0] beat_q[$];
   logic          user_acc;
   logic          mv;
   logic [MW-1:0] e_data_m, e_data_l;
   logic [R-1:0]  e_keep_m, e_keep_l;
   logic [CW-1:0] e_bc;
   logic          e_last, e_user;

   int rdy_pct  = 100;
   int hold_low = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_clear();
      beat_q.delete();
      user_acc = 1'b0;
      mv       = 1'b0;
      e_data_m = '0; e_data_l = '0;
      e_keep_m = '0; e_keep_l = '0;
      e_bc     = '0; e_last   = 1'b0; e_user = 1'b0;
   endtask

   task automatic check_outputs();
      chk("s_tready_msb", 64'(s_tready_m), 64'(!mv || m_tready));
      chk("s_tready_lsb", 64'(s_tready_l), 64'(!mv || m_tready));
      chk("tvalid_msb",   64'(tvalid_m),   64'(mv));
      chk("tvalid_lsb",   64'(tvalid_l),   64'(mv));
      chk("tdata_msb",    64'(tdata_m),    64'(e_data_m));
      chk("tdata_lsb",    64'(tdata_l),    64'(e_data_l));
      chk("tkeep_msb",    64'(tkeep_m),    64'(e_keep_m));
      chk("tkeep_lsb",    64'(tkeep_l),    64'(e_keep_l));
      chk("bcount_msb",   64'(bc_m),       64'(e_bc));
      chk("bcount_lsb",   64'(bc_l),       64'(e_bc));
      chk("tlast_msb",    64'(tlast_m),    64'(e_last));
      chk("tlast_lsb",    64'(tlast_l),    64'(e_last));
      chk("tuser_msb",    64'(tuser_m),    64'(e_user));
      chk("tuser_lsb",    64'(tuser_l),    64'(e_user));
   endtask

   // Advance the model by one clock using the current inputs.
   task automatic model_step(output bit accepted);
      bit out_hs;
      int n;
      out_hs   = mv && m_tready;
      accepted = s_tvalid && (!mv || m_tready);
      if (out_hs) mv = 1'b0;
      if (accepted) begin
         beat_q.push_back(s_tdata);
         user_acc = user_acc | s_tuser;
         if (beat_q.size() == R || s_tlast) begin
            n        = beat_q.size();
            e_data_m = '0; e_data_l = '0;
            e_keep_m = '0; e_keep_l = '0;
            for (int k = 0; k < n; k++) begin
               e_data_m[(R-1-k)*SW +: SW] = beat_q[k];
               e_data_l[k*SW +: SW]       = beat_q[k];
               e_keep_m[R-1-k]            = 1'b1;
               e_keep_l[k]                = 1'b1;
            end
            e_bc     = CW'(n - 1);
            e_last   = s_tlast;
            e_user   = user_acc;
            mv       = 1'b1;
            beat_q.delete();
            user_acc = 1'b0;
         end
      end
   endtask

   function automatic logic pick_ready();
      if (hold_low > 0) begin
         hold_low--;
         return 1'b0;
      end
      return ($urandom_range(0, 99) < rdy_pct);
   endfunction

   task automatic cycle(output bit accepted);
      m_tready = pick_ready();
      @(negedge clk);
      check_outputs();
      model_step(accepted);
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [SW-1:0] d, input logic u, input logic l);
      bit acc;
      int tries;
      s_tvalid = 1'b1; s_tdata = d; s_tuser = u; s_tlast = l;
      acc   = 1'b0;
      tries = 0;
      while (!acc && tries < 100) begin
         cycle(acc);
         tries++;
      end
      if (!acc) chk("send_timeout", 64'(acc), 64'(1));
      s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
   endtask

   task automatic idle(input int n);
      bit acc;
      s_tvalid = 1'b0;
      for (int i = 0; i < n; i++) cycle(acc);
   endtask

   task automatic drain();
      bit acc;
      int tries;
      s_tvalid = 1'b0;
      hold_low = 0;
      rdy_pct  = 100;
      tries    = 0;
      while (mv && tries < 50) begin
         cycle(acc);
         tries++;
      end
      if (mv) chk("drain_timeout", 64'(mv), 64'(0));
   endtask

   task automatic do_reset();
      rstn_i = 1'b0;
      #2;
      model_clear();
      chk("rst_tdata",    64'(tdata_m),    64'(0));
      chk("rst_tkeep",    64'(tkeep_m),    64'(0));
      chk("rst_bcount",   64'(bc_m),       64'(0));
      chk("rst_tvalid",   64'(tvalid_m),   64'(0));
      chk("rst_tlast",    64'(tlast_m),    64'(0));
      chk("rst_tuser",    64'(tuser_m),    64'(0));
      chk("rst_s_tready", 64'(s_tready_m), 64'(1));
      chk("rst_tdata_l",  64'(tdata_l),    64'(0));
      @(posedge clk);
      #1;
      rstn_i = 1'b1;
   endtask

   initial begin
      rstn_i = 1'b0;
      s_tdata = '0; s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
      model_clear();
      #12;
      do_reset();
      idle(2);

      // Full word, no tlast.
      send_beat(8'h11, 0, 0); send_beat(8'h22, 0, 0);
      send_beat(8'h33, 0, 0); send_beat(8'h44, 0, 0);
      chk("w4_data_msb", 64'(tdata_m), 64'(32'h1122_3344));
      chk("w4_keep_msb", 64'(tkeep_m), 64'(4'b1111));
      chk("w4_bc",       64'(bc_m),    64'(3));
      chk("w4_data_lsb", 64'(tdata_l), 64'(32'h4433_2211));
      idle(2);

      // Six-byte frame: one full word then a two-lane tail.
      send_beat(8'hAA, 0, 0); send_beat(8'hBB, 0, 0);
      send_beat(8'hCC, 0, 0); send_beat(8'hDD, 0, 0);
      chk("f6_w1_data", 64'(tdata_m), 64'(32'hAABB_CCDD));
      chk("f6_w1_last", 64'(tlast_m), 64'(0));
      send_beat(8'hEE, 0, 0); send_beat(8'hFF, 0, 1);
      chk("f6_w2_data", 64'(tdata_m), 64'(32'hEEFF_0000));
      chk("f6_w2_keep", 64'(tkeep_m), 64'(4'b1100));
      chk("f6_w2_bc",   64'(bc_m),    64'(1));
      chk("f6_w2_last", 64'(tlast_m), 64'(1));
      idle(2);

      // Error flag on the second byte only taints the first word.
      for (int i = 0; i < 8; i++) begin
         send_beat(8'(i + 1), (i == 1), (i == 7));
         if (i == 3) chk("tuser_w1", 64'(tuser_m), 64'(1));
         if (i == 7) chk("tuser_w2", 64'(tuser_m), 64'(0));
      end
      idle(2);

      // Single-beat frame.
      send_beat(8'h55, 0, 1);
      chk("single_data_lsb", 64'(tdata_l), 64'(32'h0000_0055));
      chk("single_keep_lsb", 64'(tkeep_l), 64'(4'b0001));
      chk("single_bc_lsb",   64'(bc_l),    64'(0));
      chk("single_keep_msb", 64'(tkeep_m), 64'(4'b1000));
      idle(2);

      // Downstream stalls five cycles while the first word is pending.
      for (int i = 0; i < 12; i++) begin
         if (i == 4) hold_low = 5;
         send_beat(8'($urandom), 0, (i == 11));
      end
      drain();
      idle(1);

      // Reset part-way through a frame.
      send_beat(8'h9A, 0, 0); send_beat(8'h9B, 0, 0);
      do_reset();
      send_beat(8'h01, 0, 0); send_beat(8'h02, 0, 0);
      send_beat(8'h03, 0, 0); send_beat(8'h04, 0, 0);
      chk("post_rst_data", 64'(tdata_m), 64'(32'h0102_0304));
      drain();

      // Random stream under random backpressure.
      rdy_pct = 70;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         if ($urandom_range(0, 19) == 0) hold_low = $urandom_range(1, 6);
         send_beat(8'($urandom), ($urandom_range(0, 7) == 0),
                   (i == 299) || ($urandom_range(0, 5) == 0));
      end
      drain();
      idle(2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/eth_axis_rx_packer.md
ETH_AXIS_RX_PACKER -- requirements
Module: eth_axis_rx_packer

Interface
REQ-001 Parameter S_DATA_WIDTH, default 8, input lane width in bits.
REQ-002 Parameter RATIO, default 4, input lanes per output word; legal range 2..16.
REQ-003 Parameter FIRST_LANE_MSB, default 1; 1 = first received lane in the most-significant lane, 0 = first lane in the least-significant lane.
REQ-004 Derived M_DATA_WIDTH = S_DATA_WIDTH*RATIO and CNT_W = $clog2(RATIO), both local.
REQ-005 clk_i  input  1  single clock; all logic on the rising edge.
REQ-006 rstn_i  input  1  reset, asynchronous, active-low.
REQ-007 s_axis_tdata  input  S_DATA_WIDTH  input lane data.
REQ-008 s_axis_tvalid  input  1  input beat valid.
REQ-009 s_axis_tuser  input  1  input error flag.
REQ-010 s_axis_tlast  input  1  last beat of frame.
REQ-011 s_axis_tready  output  1  input beat accepted when high together with tvalid.
REQ-012 m_axis_tdata  output  M_DATA_WIDTH  packed word.
REQ-013 m_axis_tkeep  output  RATIO  per-lane valid mask; bit i covers tdata lane i (bits i*S_DATA_WIDTH upward).
REQ-014 m_axis_byte_count  output  CNT_W  number of valid lanes minus 1.
REQ-015 m_axis_tvalid, m_axis_tlast, m_axis_tuser  output  1 each  word valid, frame end, OR of tuser over the word's lanes.
REQ-016 m_axis_tready  input  1  downstream ready.

Function
REQ-017 Input beat accepted = s_axis_tvalid & s_axis_tready; s_axis_tready = !m_axis_tvalid | m_axis_tready, independent of s_axis_tvalid and s_axis_tlast.
REQ-018 Lane counter cnt (CNT_W bits) selects the lane for each accepted beat, incrementing by 1 per accepted beat not completing a word.
REQ-019 Completing beat = accepted beat with cnt == RATIO-1 or s_axis_tlast == 1.
REQ-020 Non-completing beat: store tdata in accumulator lane cnt, OR s_axis_tuser into sticky tuser_acc, no output change.
REQ-021 Completing beat: load output register with accumulated lanes plus current beat in the same cycle; m_axis_tvalid = 1 on the next clock edge (latency 1 cycle from final beat).
REQ-022 On completing beat: m_axis_tlast = s_axis_tlast, m_axis_tuser = tuser_acc | s_axis_tuser, m_axis_byte_count = cnt, m_axis_tkeep = cnt+1 lanes set in arrival order; cnt and tuser_acc cleared.
REQ-023 Lanes not received in a partial word SHALL output as zero; corresponding tkeep bits zero.
REQ-024 Lane mapping: FIRST_LANE_MSB=1 puts arrival k in lane RATIO-1-k; FIRST_LANE_MSB=0 puts arrival k in lane k.
REQ-025 Output register holds all m_axis_* stable while m_axis_tvalid & !m_axis_tready.
REQ-026 Output handshake with no completing beat in same cycle clears m_axis_tvalid; handshake plus completing beat in same cycle loads the new word (no bubble).
REQ-027 Sustained throughput one input beat per cycle while m_axis_tready high; no beat lost or duplicated under any backpressure pattern.
REQ-028 Single-beat frame (tlast on cnt=0) produces one word, byte_count 0, one tkeep bit.
REQ-029 tuser on any lane flags only the word containing that lane; tuser_acc never carries into the next word.

Reset
REQ-030 rstn_i low asynchronously clears cnt, accumulator, tuser_acc, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, m_axis_tkeep, m_axis_byte_count to 0; s_axis_tready therefore reads 1.
REQ-031 Reset mid-frame discards any partial word and pending output; the first beat after release lands in the first lane.

Structure
REQ-032 Default parameter values and the lane-index function SHALL live in shared package eth_axis_pkg.
REQ-033 Block is flat; no sub-module; single output register stage, no internal FIFO.

Verification (S_DATA_WIDTH=8, RATIO=4)
REQ-034 MSB mode, bytes 11,22,33,44, no tlast, tready=1 -> one cycle after 4th beat tdata=0x11223344, tkeep=4'b1111, byte_count=3, tlast=0.
REQ-035 MSB mode, 6-byte frame AA..FF tlast on FF -> 0xAABBCCDD (tlast 0) then 0xEEFF0000, tkeep=4'b1100, byte_count=1, tlast=1.
REQ-036 tuser on 2nd byte of first word in 8-byte frame -> word 1 tuser=1, word 2 tuser=0.
REQ-037 m_axis_tready low 5 cycles with word pending, 12-byte random stream -> s_axis_tready low while output full, outputs stable, all 3 words delivered in order.
REQ-038 FIRST_LANE_MSB=0, bytes 11,22,33,44 -> 0x44332211; single byte 55 with tlast -> 0x00000055, tkeep=4'b0001, byte_count=0.
REQ-039 Reset asserted after 2 bytes of a frame -> all outputs 0, s_axis_tready=1; next 4 bytes 01..04 -> 0x01020304.
